// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  localparam int          ENTRY_W      = 64;
  localparam logic [31:0] DEF_START_PC = 32'h0000_0000;
  localparam logic [31:0] DEF_PC_STEP  = 32'd1;

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry FIFO holding fetched {pc, inst} pairs; flush beats push.
module fetch_skid_fifo
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  logic [ENTRY_W-1:0] din,
  output logic [ENTRY_W-1:0] head,
  output logic [1:0]         count,
  output logic               empty,
  output logic               full
);

  logic [ENTRY_W-1:0] mem [2];
  logic               rd_ptr;
  logic               wr_ptr;
  logic               do_push;
  logic               do_pop;

  // A push into a full queue is legal only when the head leaves this cycle.
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;
  assign empty   = (count == 2'd0);
  assign full    = (count == 2'd2);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy control; flush empties the queue outright.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage carries no reset; validity comes from count alone.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Drives the PC into a synchronous-read instruction memory, tags the
// returning word, and queues {pc, inst} pairs for decode.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] START_PC = DEF_START_PC,
  parameter logic [31:0] PC_STEP  = DEF_PC_STEP,
  parameter int          DEPTH    = 2  // the queue is fixed at two entries
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        halt,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        busy
);

  localparam logic [2:0] DEPTH_L = 3'(DEPTH);

  fetch_state_t       state;
  fetch_state_t       state_nx;
  logic [31:0]        fetch_pc;
  logic [31:0]        rsp_pc;
  logic               rsp_v;
  logic [1:0]         count;
  logic               empty;
  logic               full;
  logic [ENTRY_W-1:0] head_raw;
  fetch_entry_t       head;
  fetch_entry_t       rsp_entry;
  logic               start_ok;
  logic               redir_ok;
  logic               flush;
  logic               pop;
  logic               issue;
  logic [2:0]         occ;

  assign start_ok = start & (state != RUN);
  assign redir_ok = redirect_valid & (state != IDLE);
  assign flush    = start_ok | redir_ok;
  assign pop      = out_valid & out_ready;

  // Occupancy after this edge if we issue nothing: queued + in flight - leaving.
  assign occ   = {1'b0, count} + {2'b00, rsp_v} - {2'b00, pop};
  assign issue = (state == RUN) & ~halt & ~redirect_valid & (occ < DEPTH_L);

  assign imem_addr = fetch_pc;

  assign rsp_entry.pc   = rsp_pc;
  assign rsp_entry.inst = imem_rdata;
  assign head           = fetch_entry_t'(head_raw);

  assign out_valid = ~empty;
  assign out_pc    = empty ? 32'd0 : head.pc;
  assign out_inst  = empty ? 32'd0 : head.inst;
  assign busy      = (state == RUN) | rsp_v | ~empty;

  fetch_skid_fifo u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rsp_v),
    .pop   (pop),
    .flush (flush),
    .din   (rsp_entry),
    .head  (head_raw),
    .count (count),
    .empty (empty),
    .full  (full)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state: start leaves IDLE/HALT, halt only matters while running.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (halt)  state_nx = HALT;
      HALT:    if (start) state_nx = RUN;
      default: state_nx = IDLE;
    endcase
  end

  // PC and in-flight tag; start beats redirect, both discard the in-flight word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= START_PC;
      rsp_v    <= 1'b0;
    end else begin
      rsp_v <= issue;
      if (start_ok)      fetch_pc <= START_PC;
      else if (redir_ok) fetch_pc <= redirect_pc;
      else if (issue)    fetch_pc <= fetch_pc + PC_STEP;
    end
  end

  // PC of the word the memory returns next cycle; only meaningful with rsp_v.
  always_ff @(posedge clk) begin
    if (issue) rsp_pc <= fetch_pc;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Sequences the program counter into the synchronous-read instruction memory and tracks which returned words are real.
- Buffers fetched {pc, inst} pairs in a 2-entry queue and presents them to decode with a valid/ready handshake.
- Handles start, branch/jump redirect with squash, and halt.
- Sits between the instruction memory and the decode stage of the CPU.

Parameters:
- START_PC, 32'h0000_0000, PC loaded on start.
- PC_STEP, 32'd1, PC increment per issued fetch. The memory is word-indexed.
- DEPTH, 2, output queue entries. Only 2 is supported.

Ports:
- clk  in  1  clock, all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse; honoured only in IDLE or HALT.
- halt  in  1  level; stop issuing new fetches.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_pc  in  32  target PC.
- imem_addr  out  32  address to the instruction memory; always equals fetch_pc.
- imem_rdata  in  32  memory data for the address sampled at the previous edge.
- out_valid  out  1  queue head is valid.
- out_ready  in  1  decode accepts the head.
- out_inst  out  32  head instruction; 0 when the queue is empty.
- out_pc  out  32  head PC; 0 when the queue is empty.
- busy  out  1  high when state is RUN, or a fetch is in flight, or the queue is non-empty.

Behaviour:
- Reset values (rst_n low, immediate, no clock needed):
  - state = IDLE, fetch_pc = START_PC, queue empty, in-flight flag rsp_v = 0.
  - out_valid = 0, out_inst = 0, out_pc = 0, busy = 0.
- State machine:
  - IDLE --start--> RUN.
  - RUN --halt--> HALT.
  - HALT --start--> RUN.
  - start is ignored in RUN. halt is ignored in IDLE and HALT.
- Start: on the sampled edge, fetch_pc <= START_PC and the queue is flushed.
- Issue (combinational, this cycle):
  - issue = (state == RUN) & ~halt & ~redirect_valid & ((count - pop + rsp_v) < DEPTH).
  - pop = out_valid & out_ready.
- On an edge where issue = 1:
  - rsp_v <= 1, rsp_pc <= fetch_pc, fetch_pc <= fetch_pc + PC_STEP (mod 2^32; 0xFFFFFFFF wraps to 0).
  - When issue = 0, rsp_v <= 0.
  - imem_addr is always fetch_pc. The memory reads every cycle; reads not flagged by rsp_v are ignored.
- Response: when rsp_v = 1, {rsp_pc, imem_rdata} is pushed into the queue at the next edge.
- Latency and throughput:
  - start sampled at edge k → out_valid first rises after edge k+2.
  - Sustained rate is 1 instruction/cycle while out_ready = 1.
- Backpressure:
  - Issue stops when queue plus in-flight would exceed DEPTH.
  - imem_addr holds its value.
  - No word is dropped or duplicated.
- Redirect (RUN or HALT):
  - On the sampled edge the queue is flushed, rsp_v <= 0 (any in-flight response is discarded), and fetch_pc <= redirect_pc.
  - No issue occurs in the redirect cycle.
  - First redirected instruction appears after edge k+2.
  - A handshake that completes in the redirect cycle counts as consumed.
- Priority at one edge: reset > start > redirect flush > push/pop.
  - push and pop in the same cycle keep count unchanged.
- halt together with redirect: flush and PC load both happen, and state goes to HALT.
- Halt:
  - No new issue.
  - The in-flight response is still pushed.
  - The queue drains normally.
  - busy falls once the queue is empty and rsp_v = 0.
- Reset mid-operation: everything clears immediately, including in-flight state.

Decomposition:
- fetch_pkg holds:
  - fetch_state_t {IDLE, RUN, HALT}.
  - fetch_entry_t {pc[31:0], inst[31:0]}.
  - Default START_PC and PC_STEP constants.
- Sub-module fetch_skid_fifo:
  - 2-entry FIFO with push, pop and synchronous flush, plus count, head and empty/full outputs.
  - Same clk/rst_n as fetch_sequencer.
  - flush has priority over push in the same cycle.

Test Plan:
- Memory preloaded with imem[i] = 32'h100 + i; start pulse at edge 0 with out_ready = 1 → out_valid rises after edge 2. Outputs are pc 0,1,2,… with inst 0x100,0x101,… on consecutive cycles; busy is high from edge 0.
- Running; out_ready = 0 for 6 cycles → count reaches 2 and imem_addr freezes. Release out_ready → the pc sequence continues with no gap and no repeat.
- redirect_valid with redirect_pc = 0x20 on the cycle out_pc = 3 → no entries with pc 4 or 5 appear. Two cycles later out_pc = 0x20, out_inst = 0x120.
- halt asserted while running → at most the in-flight word plus the queued words are delivered, then out_valid = 0 and busy = 0. A later start resumes at pc 0.
- Redirect to 0xFFFF_FFFF → delivered pcs are 0xFFFF_FFFF then 0x0000_0000.
- rst_n pulsed low between edges mid-stream → out_valid, out_pc, out_inst and busy go to 0 immediately. After release, nothing issues until start.
